// File: rtl/data_mem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   F3_*    : Funct3 access size/sign encodings.
//   state_t : FSM state encoding (IDLE=0, REQ=1, DONE=2).
package data_mem_lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/data_mem_lsu_align.sv
// Combinational alignment for the LSU.
// Request side (from the core, sampled in IDLE):
//   f3, is_store, off, wdata -> be, wdata_sh, bad (misaligned / illegal Funct3)
// Load side (registered access, used while the bus returns data):
//   ld_f3, ld_off, rdata     -> ld_data (shifted and sign/zero extended)
module lsu_align
  import data_mem_lsu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic        is_store,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic        bad,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);
  logic [4:0]  sh;
  logic [4:0]  ld_sh;
  logic [31:0] rsh;

  assign sh    = {off, 3'b000};
  assign ld_sh = {ld_off, 3'b000};
  assign rsh   = rdata >> ld_sh;

  always_comb begin
    be       = 4'b0000;
    wdata_sh = '0;
    bad      = 1'b0;
    case (f3)
      F3_B, F3_BU: begin
        be       = 4'b0001 << off;
        wdata_sh = {24'h0, wdata[7:0]} << sh;
      end
      F3_H, F3_HU: begin
        be       = 4'b0011 << off;
        wdata_sh = {16'h0, wdata[15:0]} << sh;
        bad      = off[0];
      end
      F3_W: begin
        be       = 4'b1111;
        wdata_sh = wdata;
        bad      = |off;
      end
      default: bad = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (is_store && f3[2]) bad = 1'b1;
  end

  always_comb begin
    ld_data = rsh;
    case (ld_f3)
      F3_B:    ld_data = {{24{rsh[7]}}, rsh[7:0]};
      F3_BU:   ld_data = {24'h0, rsh[7:0]};
      F3_H:    ld_data = {{16{rsh[15]}}, rsh[15:0]};
      F3_HU:   ld_data = {16'h0, rsh[15:0]};
      default: ld_data = rsh;
    endcase
  end
endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit between the core datapath and a handshaked data bus.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   MemRead/MemWrite       : load/store request (store wins if both)
//   Funct3, ALUResult      : access size/sign, byte address
//   WriteData / ReadData   : store data in, extended load data out
//   Stall                  : holds the core while an access is in flight
//   MisalignErr, BusErr    : one-cycle error pulses
//   BusReq/BusWe/BusAddr/BusBE/BusWData, BusAck/BusRData : memory bus
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              MisalignErr,
  output logic              BusErr,
  output logic              BusReq,
  output logic              BusWe,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [3:0]        BusBE,
  output logic [31:0]       BusWData,
  input  logic              BusAck,
  input  logic [31:0]       BusRData
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              we_q, mis_q, berr_q;

  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_c;
  logic        bad_c, accept, reject, timeout;

  lsu_align u_align (
    .f3       (Funct3),
    .is_store (MemWrite),
    .off      (ALUResult[1:0]),
    .wdata    (WriteData),
    .be       (be_c),
    .wdata_sh (wdata_c),
    .bad      (bad_c),
    .ld_f3    (f3_q),
    .ld_off   (off_q),
    .rdata    (BusRData),
    .ld_data  (ld_c)
  );

  // Last REQ cycle before abort: counter started at 0 on entry.
  assign timeout = (cnt_q == CW'(TIMEOUT - 1)) && !BusAck;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: if (MemRead || MemWrite) begin
        if (bad_c) reject = 1'b1;
        else begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ:     if (BusAck || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mis_q   <= reject;
      berr_q  <= (state_q == REQ) && timeout;
      if (accept) begin
        addr_q  <= {ALUResult[ADDR_W-1:2], 2'b00};
        off_q   <= ALUResult[1:0];
        f3_q    <= Funct3;
        be_q    <= be_c;
        wdata_q <= wdata_c;
        we_q    <= MemWrite;
        cnt_q   <= '0;
      end else if (state_q == REQ) begin
        cnt_q <= cnt_q + 1'b1;
        if (BusAck) begin
          if (!we_q) rdata_q <= ld_c;
        end else if (timeout) begin
          rdata_q <= '0;
        end
      end
    end
  end

  assign Stall       = accept || (state_q == REQ);
  assign BusReq      = (state_q == REQ);
  assign BusWe       = we_q;
  assign BusAddr     = addr_q;
  assign BusBE       = be_q;
  assign BusWData    = wdata_q;
  assign ReadData    = rdata_q;
  assign MisalignErr = mis_q;
  assign BusErr      = berr_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, MisalignErr, BusErr, BusReq, BusWe;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [3:0]  BusBE;
  logic        BusAck;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .MisalignErr(MisalignErr),
    .BusErr(BusErr), .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr),
    .BusBE(BusBE), .BusWData(BusWData), .BusAck(BusAck), .BusRData(BusRData)
  );

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdat;
    int          dly;
    logic        mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int stl;
    @(negedge clk);
    MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
    ALUResult = v.addr; WriteData = v.wd;
    #1;
    chk({v.name, " stall_req"}, 32'(Stall), 32'(!v.mis));
    stl = Stall ? 1 : 0;
    @(negedge clk);
    MemRead = 0; MemWrite = 0;
    #1;
    if (v.mis) begin
      chk({v.name, " misalign"}, 32'(MisalignErr), 1);
      chk({v.name, " no_busreq"}, 32'(BusReq), 0);
      chk({v.name, " no_stall"}, 32'(Stall), 0);
      @(negedge clk); #1;
      chk({v.name, " misalign_pulse"}, 32'(MisalignErr), 0);
      chk({v.name, " no_busreq2"}, 32'(BusReq), 0);
      chk({v.name, " rdata_kept"}, ReadData, v.e_rd);
      return;
    end
    chk({v.name, " busreq"}, 32'(BusReq), 1);
    chk({v.name, " addr"}, BusAddr, v.e_addr);
    chk({v.name, " be"}, 32'(BusBE), 32'(v.e_be));
    chk({v.name, " wdata"}, BusWData, v.e_wd);
    chk({v.name, " we"}, 32'(BusWe), 32'(v.wr));
    for (int k = 1; k <= v.dly; k++) begin
      if (k == v.dly) begin BusAck = 1; BusRData = v.rdat; end
      #1;
      if (Stall) stl++;
      if (k > 1) @(negedge clk);
      else if (v.dly > 1) @(negedge clk);
      else @(negedge clk);
    end
    BusAck = 0; BusRData = 32'h0;
    #1;
    chk({v.name, " stall_cycles"}, stl, v.dly + 1);
    chk({v.name, " done_stall"}, 32'(Stall), 0);
    chk({v.name, " done_busreq"}, 32'(BusReq), 0);
    chk({v.name, " readdata"}, ReadData, v.e_rd);
  endtask

  initial begin
    int reqs;
    rst_n = 0; MemRead = 0; MemWrite = 0; Funct3 = 0; ALUResult = 0;
    WriteData = 0; BusAck = 0; BusRData = 0;

    //            name   rd wr f3      addr       wd            rdat          dly mis e_addr     e_be     e_wd          e_rd
    vecs[0]  = '{"SW",   0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        3, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{"SB",   0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        1, 0, 32'h100, 4'b1000, 32'hA5000000, 32'h0};
    vecs[2]  = '{"LB",   1, 0, 3'b000, 32'h102, 32'h0,        32'h0080FF00, 2, 0, 32'h100, 4'b0100, 32'h0,        32'hFFFFFF80};
    vecs[3]  = '{"LBU",  1, 0, 3'b100, 32'h102, 32'h0,        32'h0080FF00, 1, 0, 32'h100, 4'b0100, 32'h0,        32'h00000080};
    vecs[4]  = '{"LH",   1, 0, 3'b001, 32'h102, 32'h0,        32'h80011234, 1, 0, 32'h100, 4'b1100, 32'h0,        32'hFFFF8001};
    vecs[5]  = '{"SH",   0, 1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0,        2, 0, 32'h100, 4'b1100, 32'hBEEF0000, 32'hFFFF8001};
    vecs[6]  = '{"LHU",  1, 0, 3'b101, 32'h100, 32'h0,        32'h1234F00D, 1, 0, 32'h100, 4'b0011, 32'h0,        32'h0000F00D};
    vecs[7]  = '{"LW",   1, 0, 3'b010, 32'h204, 32'h0,        32'hCAFEBABE, 1, 0, 32'h204, 4'b1111, 32'h0,        32'hCAFEBABE};
    vecs[8]  = '{"LB1",  1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1, 0, 32'h100, 4'b0010, 32'h0,        32'h0000007F};
    vecs[9]  = '{"LWmis",1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        1, 1, 32'h0,   4'b0000, 32'h0,        32'h0000007F};
    vecs[10] = '{"LHmis",1, 0, 3'b001, 32'h103, 32'h0,        32'h0,        1, 1, 32'h0,   4'b0000, 32'h0,        32'h0000007F};
    vecs[11] = '{"SBUil",0, 1, 3'b100, 32'h100, 32'h0,        32'h0,        1, 1, 32'h0,   4'b0000, 32'h0,        32'h0000007F};
    vecs[12] = '{"F3ill",1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 1, 32'h0,   4'b0000, 32'h0,        32'h0000007F};
    vecs[13] = '{"RW",   1, 1, 3'b010, 32'h300, 32'h11223344, 32'hFFFFFFFF, 1, 0, 32'h300, 4'b1111, 32'h11223344, 32'h0000007F};

    // Reset state
    #12;
    chk("rst ReadData", ReadData, 0);
    chk("rst Stall", 32'(Stall), 0);
    chk("rst BusReq", 32'(BusReq), 0);
    chk("rst BusAddr", BusAddr, 0);
    chk("rst errs", {30'h0, MisalignErr, BusErr}, 0);
    chk("rst BE/We", {27'h0, BusWe, BusBE}, 0);
    @(negedge clk); rst_n = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during REQ: bus request and stall drop at once, outputs clear.
    @(negedge clk);
    MemRead = 1; Funct3 = 3'b010; ALUResult = 32'h500;
    @(negedge clk);
    MemRead = 0;
    #1 chk("mid busreq_before", 32'(BusReq), 1);
    #2 rst_n = 0;
    #1;
    chk("mid busreq", 32'(BusReq), 0);
    chk("mid stall", 32'(Stall), 0);
    chk("mid readdata", ReadData, 0);
    chk("mid busaddr", BusAddr, 0);
    @(negedge clk); rst_n = 1;

    // Load with no ack: 4 REQ cycles then BusErr with ReadData cleared.
    run_vec('{"LWpre", 1, 0, 3'b010, 32'h600, 32'h0, 32'h89ABCDEF, 1, 0,
              32'h600, 4'b1111, 32'h0, 32'h89ABCDEF});
    @(negedge clk);
    MemRead = 1; Funct3 = 3'b010; ALUResult = 32'h700;
    reqs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      MemRead = 0;
      #1;
      if (BusErr) break;
      if (BusReq) reqs++;
    end
    chk("to req_cycles", reqs, 4);
    chk("to buserr", 32'(BusErr), 1);
    chk("to readdata", ReadData, 0);
    chk("to stall", 32'(Stall), 0);
    @(negedge clk); #1;
    chk("to buserr_pulse", 32'(BusErr), 0);

    // Ack in IDLE is ignored.
    BusAck = 1; BusRData = 32'h55555555;
    @(negedge clk); #1;
    BusAck = 0;
    chk("idle_ack readdata", ReadData, 0);
    chk("idle_ack stall", 32'(Stall), 0);
    chk("idle_ack busreq", 32'(BusReq), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
